// File: rtl/flag_pkg.sv
// Shared constants for the WISC flag/branch controller: opcodes, condition codes,
// flag bit positions and the FSM state encoding.
package flag_pkg;

    localparam logic [3:0] OP_ADD = 4'b0000;
    localparam logic [3:0] OP_SUB = 4'b0001;
    localparam logic [3:0] OP_XOR = 4'b0010;
    localparam logic [3:0] OP_SLL = 4'b0100;
    localparam logic [3:0] OP_SRA = 4'b0101;
    localparam logic [3:0] OP_ROR = 4'b0110;

    localparam logic [2:0] CC_NE     = 3'b000;
    localparam logic [2:0] CC_EQ     = 3'b001;
    localparam logic [2:0] CC_GT     = 3'b010;
    localparam logic [2:0] CC_LT     = 3'b011;
    localparam logic [2:0] CC_GTE    = 3'b100;
    localparam logic [2:0] CC_LTE    = 3'b101;
    localparam logic [2:0] CC_OVFL   = 3'b110;
    localparam logic [2:0] CC_ALWAYS = 3'b111;

    localparam int N_BIT = 2;
    localparam int Z_BIT = 1;
    localparam int V_BIT = 0;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } state_e;

endpackage

// File: rtl/cond_eval.sv
// Combinational branch-condition evaluator: condition code plus {N,Z,V} to taken.
module cond_eval
    import flag_pkg::*;
(
    input  logic [2:0] ccc,
    input  logic [2:0] flags,
    output logic       taken
);

    logic n;
    logic z;
    logic v;

    assign n = flags[N_BIT];
    assign z = flags[Z_BIT];
    assign v = flags[V_BIT];

    always_comb begin
        taken = 1'b0;
        case (ccc)
            CC_NE:     taken = !z;
            CC_EQ:     taken = z;
            CC_GT:     taken = !z && !n;
            CC_LT:     taken = n;
            CC_GTE:    taken = z || (!z && !n);
            CC_LTE:    taken = n || z;
            CC_OVFL:   taken = v;
            CC_ALWAYS: taken = 1'b1;
            default:   taken = 1'b0;
        endcase
    end

endmodule

// File: rtl/branch_flag_ctrl.sv
// Owns the N/Z/V flags and resolves ID-stage branches, stalling once on a flag hazard.
// Build option: define FLAG_FWD_EN to resolve on forwarded EX flags with no stall.
//
// state | meaning
// IDLE  | normal; branches resolve same cycle unless an EX flag writer is pending
// WAIT  | one stall cycle taken; flags now hold the writer's result, resolve now
module branch_flag_ctrl
    import flag_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ex_valid,
    input  logic [3:0] ex_opcode,
    input  logic       ex_n,
    input  logic       ex_z,
    input  logic       ex_v,
    input  logic       br_valid,
    input  logic [2:0] br_ccc,
    input  logic       flush,
    output logic [2:0] flags,
    output logic       stall,
    output logic       br_resolve,
    output logic       br_taken
);

    state_e     state_q, state_d;
    logic [2:0] flags_q, flags_d;
    logic [2:0] wr_en;
    logic [2:0] ex_flags;
    logic [2:0] eval_flags;
    logic       cond_taken;
    logic       resolve;

    always_comb begin
        wr_en = 3'b000;
        case (ex_opcode)
            OP_ADD, OP_SUB:                 wr_en = 3'b111;
            OP_XOR, OP_SLL, OP_SRA, OP_ROR: wr_en = 3'b010;
            default:                        wr_en = 3'b000;
        endcase
    end

    assign ex_flags = {ex_n, ex_z, ex_v};

    // Commit ignores flush: the EX instruction is older than the redirect.
    always_comb begin
        flags_d = flags_q;
        if (ex_valid) begin
            flags_d = (flags_q & ~wr_en) | (ex_flags & wr_en);
        end
    end

`ifdef FLAG_FWD_EN
    assign eval_flags = flags_d;
`else
    logic ex_writer;
    assign ex_writer  = ex_valid && (wr_en != 3'b000);
    assign eval_flags = flags_q;
`endif

    cond_eval u_cond_eval (
        .ccc   (br_ccc),
        .flags (eval_flags),
        .taken (cond_taken)
    );

    always_comb begin
        state_d = state_q;
        stall   = 1'b0;
        resolve = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (!flush && br_valid) begin
`ifdef FLAG_FWD_EN
                    resolve = 1'b1;
`else
                    if (ex_writer) begin
                        stall   = 1'b1;
                        state_d = ST_WAIT;
                    end else begin
                        resolve = 1'b1;
                    end
`endif
                end
            end
            ST_WAIT: begin
                state_d = ST_IDLE;
                if (!flush) begin
                    resolve = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign br_resolve = resolve;
    assign br_taken   = resolve && cond_taken;
    assign flags      = flags_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            flags_q <= 3'b000;
        end else begin
            state_q <= state_d;
            flags_q <= flags_d;
        end
    end

endmodule
